// File: rtl/mcdp_pkg.sv
// Shared step encoding, control codes and immediate extender for the
// multicycle RV32 datapath.
package mcdp_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } step_t;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_REG    = 2'b10;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_LINK = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // f holds instruction bits [31:7]; f[k] is instruction bit k+7.
  function automatic logic [31:0] extendImm(input logic [24:0] f,
                                            input logic [2:0]  immSrc);
    logic [31:0] imm;
    imm = '0;
    case (immSrc)
      IMM_I:   imm = {{20{f[24]}}, f[24:13]};
      IMM_S:   imm = {{20{f[24]}}, f[24:18], f[4:0]};
      IMM_B:   imm = {{19{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
      IMM_J:   imm = {{11{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
      IMM_U:   imm = {f[24:5], 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mcdp_fsm.sv
// Step sequencer: FETCH/DECODE/EXEC/MEM/WB with registered memory
// request and write strobe.
module mcdp_fsm
  import mcdp_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_memReady,
  input  logic       i_memRead,
  input  logic       i_memWrite,
  output logic [2:0] o_state,
  output logic       o_memReq,
  output logic       o_memWe
);

  step_t r_state;
  logic  r_memReq;
  logic  r_memWe;

  // Advance the step and precompute the request strobes for the next step.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_FETCH;
      r_memReq <= 1'b0;
      r_memWe  <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (r_memReq && i_memReady) begin
            r_state  <= ST_DECODE;
            r_memReq <= 1'b0;
          end else begin
            r_memReq <= 1'b1;
          end
        end
        ST_DECODE: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (i_memRead || i_memWrite) begin
            r_state  <= ST_MEM;
            r_memReq <= 1'b1;
            r_memWe  <= i_memWrite;
          end else begin
            r_state  <= ST_WB;
          end
        end
        ST_MEM: begin
          if (r_memReq && i_memReady) begin
            r_memWe <= 1'b0;
            if (r_memWe) begin
              r_state  <= ST_FETCH;
              r_memReq <= 1'b1;
            end else begin
              r_state  <= ST_WB;
              r_memReq <= 1'b0;
            end
          end
        end
        ST_WB: begin
          r_state  <= ST_FETCH;
          r_memReq <= 1'b1;
        end
        default: begin
          r_state  <= ST_FETCH;
          r_memReq <= 1'b0;
          r_memWe  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_memReq = r_memReq;
  assign o_memWe  = r_memWe;

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32 datapath: register file, extender, ALU and result
// select sequenced over one shared instruction/data memory port.
module multicycle_datapath
  import mcdp_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [31:0]     Instr,
  input  logic [1:0]      PCSrc,
  input  logic [1:0]      ResultSrc,
  input  logic [2:0]      ALUControl,
  input  logic            ALUSrc,
  input  logic [2:0]      ImmSrc,
  input  logic            Up,
  input  logic            Sub,
  input  logic            RegWrite,
  input  logic            MemRead,
  input  logic            MemWrite,
  output logic            Zero,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [2:0]      state,
  output logic [XLEN-1:0] instret
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] r_pc, r_oldPc, r_a, r_b, r_imm, r_aluOut, r_memData, r_instret;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_rf [0:31];

  logic [2:0]      w_state;
  logic            w_memReq, w_memWe, w_memFire;
  logic            w_fetchDone, w_loadDone, w_retire;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_rd1, w_rd2, w_immExt;
  logic [XLEN-1:0] w_srcA, w_srcB, w_srcBInv, w_sum, w_aluResult;
  logic            w_doSub, w_lt;
  logic [XLEN-1:0] w_pcPlus4, w_pcTarget, w_pcNext, w_result;

  mcdp_fsm u_fsm (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_memReady (mem_ready),
    .i_memRead  (MemRead),
    .i_memWrite (MemWrite),
    .o_state    (w_state),
    .o_memReq   (w_memReq),
    .o_memWe    (w_memWe)
  );

  assign w_memFire   = w_memReq & mem_ready;
  assign w_fetchDone = (w_state == ST_FETCH) & w_memFire;
  assign w_loadDone  = (w_state == ST_MEM) & w_memFire & ~w_memWe;
  assign w_retire    = (w_state == ST_WB) | ((w_state == ST_MEM) & w_memFire & w_memWe);

  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_rd  = r_ir[11:7];

  assign w_rd1    = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
  assign w_rd2    = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
  assign w_immExt = XLEN'($signed(extendImm(r_ir[31:7], ImmSrc)));

  assign w_srcA    = Up ? '0 : r_a;
  assign w_srcB    = ALUSrc ? r_imm : r_b;
  assign w_doSub   = Sub | (ALUControl == ALU_SUB) | (ALUControl == ALU_SLT);
  assign w_srcBInv = w_doSub ? ~w_srcB : w_srcB;
  assign w_sum     = w_srcA + w_srcBInv + {{(XLEN-1){1'b0}}, w_doSub};
  assign w_lt      = $signed(w_srcA) < $signed(w_srcB);

  // ALU operation select.
  always_comb begin
    w_aluResult = w_sum;
    case (ALUControl)
      ALU_ADD, ALU_SUB: w_aluResult = w_sum;
      ALU_AND: w_aluResult = w_srcA & w_srcB;
      ALU_OR:  w_aluResult = w_srcA | w_srcB;
      ALU_XOR: w_aluResult = w_srcA ^ w_srcB;
      ALU_SLT: w_aluResult = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLL: w_aluResult = w_srcA << w_srcB[SHW-1:0];
      ALU_SRL: w_aluResult = w_srcA >> w_srcB[SHW-1:0];
      default: w_aluResult = w_sum;
    endcase
  end

  assign Zero = (w_aluResult == '0);

  assign w_pcPlus4  = r_oldPc + XLEN'(4);
  assign w_pcTarget = r_oldPc + r_imm;

  // Next-PC select; the reserved code falls back to sequential flow.
  always_comb begin
    w_pcNext = w_pcPlus4;
    case (PCSrc)
      PCSRC_BRANCH: w_pcNext = w_pcTarget;
      PCSRC_REG:    w_pcNext = {w_aluResult[XLEN-1:1], 1'b0};
      default:      w_pcNext = w_pcPlus4;
    endcase
  end

  // Write-back value select; code 11 aliases the ALU output.
  always_comb begin
    w_result = r_aluOut;
    case (ResultSrc)
      RES_MEM:  w_result = r_memData;
      RES_LINK: w_result = w_pcPlus4;
      default:  w_result = r_aluOut;
    endcase
  end

  // Register file write in WB; x0 is never written and contents are not reset.
  always_ff @(posedge clk) begin
    if ((w_state == ST_WB) && RegWrite && (w_rd != 5'd0)) begin
      r_rf[w_rd] <= w_result;
    end
  end

  // Architectural and step-to-step registers, each loaded in its own step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_oldPc   <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_aluOut  <= '0;
      r_memData <= '0;
      r_instret <= '0;
    end else begin
      if (w_fetchDone) begin
        r_ir    <= mem_rdata[31:0];
        r_oldPc <= r_pc;
      end
      if (w_state == ST_DECODE) begin
        r_a   <= w_rd1;
        r_b   <= w_rd2;
        r_imm <= w_immExt;
      end
      if (w_state == ST_EXEC) begin
        r_aluOut <= w_aluResult;
        r_pc     <= w_pcNext;
      end
      if (w_loadDone) begin
        r_memData <= mem_rdata;
      end
      if (w_retire) begin
        r_instret <= r_instret + XLEN'(1);
      end
    end
  end

  assign Instr     = r_ir;
  assign mem_req   = w_memReq;
  assign mem_we    = w_memWe;
  assign mem_addr  = (w_state == ST_MEM) ? r_aluOut : r_pc;
  assign mem_wdata = r_b;
  assign state     = w_state;
  assign instret   = r_instret;

endmodule
